// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] IMEM_NOP         = 32'h00000013;
  localparam int          IMEM_MAX_LATENCY = 4;

  // One slot of the response delay line.
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] rdata;
  } imem_entry_t;

  // Misaligned, below BASE_ADDR, or word index past the end of the store.
  function automatic logic imem_addr_fault(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/imem_delay_line.sv
// Fixed-depth response pipeline. Stage 0 is loaded on every edge with the
// entry for the request accepted on that edge (valid=0 when none), so the
// last stage is the registered response output.
module imem_delay_line
  import imem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  imem_entry_t i_in,
  output imem_entry_t o_out
);

  imem_entry_t r_stage [LATENCY];

  // Shift entries toward the output; a flush kills everything already in the
  // line but keeps stage 0, which holds the request accepted on this edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_in;
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
        if (i_flush) r_stage[i].valid <= 1'b0;
      end
    end
  end

  assign o_out = r_stage[LATENCY-1];

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder: word-aligned reads with fixed latency,
// in-order responses, branch flush of in-flight reads, side-band image load.
//
// Handshake: a request is taken on a rising edge where i_req_valid and
// o_req_ready are both high; o_req_ready drops only while a load is being
// written. Each accepted, unflushed request yields exactly one o_rsp_valid
// pulse LATENCY cycles later; there is no response-side backpressure.
module imem_server
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter int          LATENCY     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_fault,
  input  logic        i_flush,
  input  logic        i_load_en,
  input  logic [31:0] i_load_addr,
  input  logic [31:0] i_load_data,
  output logic [2:0]  o_inflight
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [2:0]       r_inflight;
  logic             w_accept;
  logic             w_req_fault;
  logic             w_load_fault;
  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_load_idx;
  imem_entry_t      w_in;
  imem_entry_t      w_out;

  assign o_req_ready  = ~i_load_en;
  assign w_accept     = i_req_valid & o_req_ready;
  assign w_req_fault  = imem_addr_fault(i_req_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign w_load_fault = imem_addr_fault(i_load_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  assign w_req_idx    = IDX_W'((i_req_addr - BASE_ADDR) >> 2);
  assign w_load_idx   = IDX_W'((i_load_addr - BASE_ADDR) >> 2);

  // Build the stage-0 entry: store word captured at acceptance, or NOP on fault.
  always_comb begin
    w_in = '0;
    if (w_accept) begin
      w_in.valid = 1'b1;
      w_in.fault = w_req_fault;
      w_in.rdata = w_req_fault ? IMEM_NOP : r_mem[w_req_idx];
    end
  end

  // Backing store write; bad load addresses are dropped. Contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_load_en && !w_load_fault) r_mem[w_load_idx] <= i_load_data;
  end

  imem_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_in    (w_in),
    .o_out   (w_out)
  );

  // Count requests accepted but not yet retired by their response pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inflight <= '0;
    end else if (i_flush) begin
      r_inflight <= {2'b00, w_accept};
    end else begin
      r_inflight <= r_inflight + {2'b00, w_accept} - {2'b00, w_out.valid};
    end
  end

  assign o_rsp_valid = w_out.valid;
  assign o_rsp_fault = w_out.fault;
  assign o_rsp_rdata = w_out.rdata;
  assign o_inflight  = r_inflight;

endmodule

// File: tb/tb_imem_server.sv
// Bench for imem_server: one instance at LATENCY=1 and one at LATENCY=3
// share the same stimulus; each has its own expected-response queue.
module tb_imem_server;

  logic        i_clk;
  logic        i_rst;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_flush;
  logic        i_load_en;
  logic [31:0] i_load_addr;
  logic [31:0] i_load_data;

  logic        rdy1, v1, f1;
  logic [31:0] rd1;
  logic [2:0]  inf1;
  logic        rdy3, v3, f3;
  logic [31:0] rd3;
  logic [2:0]  inf3;

  // Entry: {due negedge[15:0], fault, rdata[31:0]}
  logic [48:0] exp_q1[$];
  logic [48:0] exp_q3[$];
  int          n_vec;
  int          n_err;
  int          neg_cnt;

  imem_server #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .o_req_ready(rdy1), .o_rsp_valid(v1), .o_rsp_rdata(rd1), .o_rsp_fault(f1),
    .i_flush(i_flush), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
    .i_load_data(i_load_data), .o_inflight(inf1));

  imem_server #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_dut3 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .o_req_ready(rdy3), .o_rsp_valid(v3), .o_rsp_rdata(rd3), .o_rsp_fault(f3),
    .i_flush(i_flush), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
    .i_load_data(i_load_data), .o_inflight(inf3));

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, n_vec=%0d", n_vec);
    $fatal(1, "timeout");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [31:0] rd, input logic f);
    logic [48:0] e;
    logic        have;
    string       tag;
    tag  = (d == 0) ? "l1" : "l3";
    have = (d == 0) ? (exp_q1.size() > 0) : (exp_q3.size() > 0);
    e    = '0;
    if (have) e = (d == 0) ? exp_q1[0] : exp_q3[0];
    if (v === 1'b1) begin
      if (!have) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected_%s: got rdata %h fault %b, expected no response (t=%0t)",
                 tag, rd, f, $time);
      end else begin
        if (d == 0) void'(exp_q1.pop_front()); else void'(exp_q3.pop_front());
        chk({"rsp_rdata_", tag}, rd, e[31:0]);
        chk({"rsp_fault_", tag}, 32'(f), 32'(e[32]));
        chk({"rsp_cycle_", tag}, 32'(neg_cnt), 32'(e[48:33]));
      end
    end else if (have && (32'(e[48:33]) <= 32'(neg_cnt))) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_missing_%s: got no response, expected rdata %h fault %b (t=%0t)",
               tag, e[31:0], e[32], $time);
      if (d == 0) void'(exp_q1.pop_front()); else void'(exp_q3.pop_front());
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    neg_cnt++;
    mon(0, v1, rd1, f1);
    mon(1, v3, rd3, f3);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] ed,
                      input logic ef, input logic ld, input logic [31:0] la,
                      input logic [31:0] ldat, input logic fl);
    i_req_valid = v;
    i_req_addr  = a;
    i_load_en   = ld;
    i_load_addr = la;
    i_load_data = ldat;
    i_flush     = fl;
    #1;
    chk("req_ready_l1", 32'(rdy1), 32'(!ld));
    chk("req_ready_l3", 32'(rdy3), 32'(!ld));
    @(posedge i_clk);
    if (fl) begin
      exp_q1.delete();
      exp_q3.delete();
    end
    if (v && !ld) begin
      exp_q1.push_back({16'(neg_cnt + 1), ef, ed});
      exp_q3.push_back({16'(neg_cnt + 3), ef, ed});
    end
    #1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_load_en   = 1'b0;
    i_load_addr = '0;
    i_load_data = '0;
    i_flush     = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] ed, input logic ef);
    step(1'b1, a, ed, ef, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic chk_inflight(input string nm, input logic [2:0] e1, input logic [2:0] e3);
    chk({nm, "_l1"}, 32'(inf1), 32'(e1));
    chk({nm, "_l3"}, 32'(inf3), 32'(e3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec       = 0;
    n_err       = 0;
    neg_cnt     = 0;
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_flush     = 1'b0;
    i_load_en   = 1'b0;
    i_load_addr = '0;
    i_load_data = '0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid_l1", 32'(v1), 32'h0);
    chk("rst_valid_l3", 32'(v3), 32'h0);
    chk("rst_rdata_l1", rd1, 32'h0);
    chk("rst_fault_l3", 32'(f3), 32'h0);
    chk_inflight("rst_inflight", 3'd0, 3'd0);
    chk("rst_ready_l1", 32'(rdy1), 32'h1);
    i_rst = 1'b0;

    // Program image, plus two loads that must be dropped (would alias word 0)
    load(32'h0000_0000, 32'h1111_1111);
    load(32'h0000_0004, 32'h2222_2222);
    load(32'h0000_0008, 32'h3333_3333);
    load(32'h0000_000C, 32'h4444_4444);
    load(32'h0000_0FFC, 32'hDEAD_BEEF);
    load(32'h0000_1000, 32'h5555_5555);
    load(32'h0000_0002, 32'h6666_6666);

    // Back-to-back pair
    req(32'h0, 32'h1111_1111, 1'b0);
    req(32'h4, 32'h2222_2222, 1'b0);
    idle(4);

    // Four back-to-back; depth-3 pipe fills to 3
    req(32'h0, 32'h1111_1111, 1'b0);
    req(32'h4, 32'h2222_2222, 1'b0);
    req(32'h8, 32'h3333_3333, 1'b0);
    chk_inflight("inflight_fill", 3'd1, 3'd3);
    req(32'hC, 32'h4444_4444, 1'b0);
    chk_inflight("inflight_steady", 3'd1, 3'd3);
    idle(4);
    chk_inflight("inflight_drain", 3'd0, 3'd0);

    // Faults and the last valid word
    req(32'h0000_0002, 32'h0000_0013, 1'b1);
    req(32'h0000_1000, 32'h0000_0013, 1'b1);
    req(32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0);
    req(32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
    idle(4);

    // Flush with a same-edge redirect target
    req(32'h0, 32'h1111_1111, 1'b0);
    req(32'h4, 32'h2222_2222, 1'b0);
    step(1'b1, 32'h8, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk_inflight("inflight_flush_req", 3'd1, 3'd1);
    idle(4);
    chk_inflight("inflight_after_flush", 3'd0, 3'd0);

    // Flush alone
    req(32'h0, 32'h1111_1111, 1'b0);
    req(32'h4, 32'h2222_2222, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk_inflight("inflight_flush_only", 3'd0, 3'd0);
    idle(4);

    // Load and request together: load wins, retry sees new data
    step(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5, 1'b0);
    req(32'h10, 32'hA5A5_A5A5, 1'b0);
    idle(4);

    // Asynchronous reset with responses in flight
    req(32'h0, 32'h1111_1111, 1'b0);
    req(32'h4, 32'h2222_2222, 1'b0);
    #1;
    i_rst = 1'b1;
    exp_q1.delete();
    exp_q3.delete();
    #1;
    chk("arst_valid_l1", 32'(v1), 32'h0);
    chk("arst_valid_l3", 32'(v3), 32'h0);
    chk("arst_rdata_l1", rd1, 32'h0);
    chk_inflight("arst_inflight", 3'd0, 3'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(5);

    // Store contents survive reset
    req(32'h4, 32'h2222_2222, 1'b0);
    idle(6);

    chk("leftover_l1", 32'(exp_q1.size()), 32'h0);
    chk("leftover_l3", 32'(exp_q3.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
